// File: rtl/cpu_types_pkg.sv
// Shared CPU types: memory word, RAM status and arbiter state encodings.
// ARB_STARVE_LIMIT is the default starvation bound for memory_arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    localparam int ARB_STARVE_LIMIT = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive data grants taken while an instruction
// fetch waits; only built when ARB_STARVE_GUARD_EN is defined.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_C)) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == LIMIT_C);

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (instruction/data) arbiter onto a single RAM port; data has priority.
// Define ARB_STARVE_GUARD_EN to bound how long an instruction fetch can starve.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    arb_state_t state, next_state;

    logic dreq;
    logic ram_done;
    logic starve_force;

    assign dreq     = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS) || (ramstate == ERROR);

`ifdef ARB_STARVE_GUARD_EN
    logic starve_sat;
    logic starve_inc;
    logic starve_clr;

    assign starve_force = iREN & starve_sat;
    assign starve_inc   = (state == IDLE) && (next_state == DGNT) && iREN;
    assign starve_clr   = (state == IDLE) &&
                          ((next_state == IGNT) || ((next_state == DGNT) && !iREN));

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .CLK (CLK),
        .RST (RST),
        .inc (starve_inc),
        .clr (starve_clr),
        .sat (starve_sat)
    );
`else
    logic unused_starve_limit;

    assign unused_starve_limit = ^STARVE_LIMIT;
    assign starve_force        = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (starve_force)  next_state = IGNT;
                else if (dreq)     next_state = DGNT;
                else if (iREN)     next_state = IGNT;
            end
            // ERROR also ends the grant so the requester re-arbitrates from IDLE
            IGNT: if (!iREN || ram_done) next_state = IDLE;
            DGNT: if (!dreq || ram_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = iREN;
        dwait    = dreq;
        case (state)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (ramstate == ACCESS) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DGNT: begin
                // a write wins over a simultaneous read
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (ramstate == ACCESS) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter; expectations follow
// ARB_STARVE_GUARD_EN the same way the design does.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_err = 0;

    memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        int icnt, dcnt, first_i;

        RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        ramload = 32'hDEADBEEF; ramstate = ACCESS;

        // reset state: strobes and loads zero, iwait follows iREN
        #3;
        chk("rst_ramren", ramREN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_iload", iload, 0);
        chk("rst_iwait_req", iwait, 1);
        @(posedge CLK); #1;
        chk("rst_ramren_edge", ramREN, 0);
        iREN = 1'b0; #1;
        chk("rst_iwait_noreq", iwait, 0);
        RST = 1'b0; ramstate = FREE;
        @(negedge CLK);

        // lone instruction read, ACCESS on second grant cycle
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; #1;
        chk("i_idle_ramren", ramREN, 0);
        chk("i_idle_iwait", iwait, 1);
        @(negedge CLK);
        chk("i_gnt_ramren", ramREN, 1);
        chk("i_gnt_ramaddr", ramaddr, 32'h40);
        chk("i_gnt_busy_iwait", iwait, 1);
        ramstate = ACCESS; #1;
        chk("i_done_iwait", iwait, 0);
        chk("i_done_iload", iload, 32'hDEADBEEF);
        @(negedge CLK);
        chk("i_back_idle_ramren", ramREN, 0);
        chk("i_back_idle_iload", iload, 0);
        iREN = 1'b0; ramstate = FREE;
        @(negedge CLK);

        // simultaneous instruction read and data write (dREN also high)
        iREN = 1'b1; iaddr = 32'h44;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        ramstate = ACCESS;
        @(negedge CLK);
        chk("dw_ramwen", ramWEN, 1);
        chk("dw_ramren", ramREN, 0);
        chk("dw_ramaddr", ramaddr, 32'h80);
        chk("dw_ramstore", ramstore, 32'h1234);
        chk("dw_dwait", dwait, 0);
        chk("dw_iwait", iwait, 1);
        dREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK);
        chk("turn_ramren", ramREN, 0);
        chk("turn_ramwen", ramWEN, 0);
        chk("turn_iwait", iwait, 1);
        @(negedge CLK);
        chk("after_d_ramren", ramREN, 1);
        chk("after_d_ramaddr", ramaddr, 32'h44);
        chk("after_d_iwait", iwait, 0);
        iREN = 1'b0; ramstate = FREE;
        @(negedge CLK);

        // ERROR during DGNT re-arbitrates
        dREN = 1'b1; daddr = 32'h90; ramstate = ERROR;
        @(negedge CLK);
        chk("err_gnt_ramren", ramREN, 1);
        chk("err_gnt_ramaddr", ramaddr, 32'h90);
        chk("err_dwait", dwait, 1);
        @(negedge CLK);
        chk("err_idle_ramren", ramREN, 0);
        chk("err_idle_dwait", dwait, 1);
        @(negedge CLK);
        chk("err_regnt_ramren", ramREN, 1);
        ramstate = ACCESS; ramload = 32'hCAFE0001; #1;
        chk("err_done_dwait", dwait, 0);
        chk("err_done_dload", dload, 32'hCAFE0001);
        @(negedge CLK);
        dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);

        // granted requester drops before ACCESS
        iREN = 1'b1; iaddr = 32'h48; ramstate = BUSY;
        @(negedge CLK);
        chk("drop_gnt_ramren", ramREN, 1);
        iREN = 1'b0; #1;
        chk("drop_ramren", ramREN, 0);
        chk("drop_iwait", iwait, 0);
        @(negedge CLK);
        ramstate = ACCESS; ramload = 32'h55; #1;
        chk("drop_no_iload", iload, 0);
        ramstate = FREE;
        RST = 1'b1; #2; RST = 1'b0;
        @(negedge CLK);

        // starvation: iREN held, dREN continuously, RAM always ACCESS
        iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'hA0; ramstate = ACCESS;
        icnt = 0; dcnt = 0; first_i = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!dwait) dcnt++;
            if (ramREN && (ramaddr == 32'h40)) begin
                icnt++;
                if (first_i < 0) first_i = i;
            end
            @(negedge CLK);
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_first_ignt", first_i, 9);
        chk("starve_igrants", icnt, 2);
        chk("starve_dcompl", dcnt, 8);
`else
        chk("strict_igrants", icnt, 0);
        chk("strict_dcompl", dcnt, 10);
`endif
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        @(negedge CLK);

        // reset mid-DGNT
        dREN = 1'b1; daddr = 32'hB0; ramstate = BUSY; ramload = 32'h77;
        @(negedge CLK);
        chk("rstmid_pre_ramren", ramREN, 1);
        #2; RST = 1'b1; ramstate = ACCESS; #1;
        chk("rstmid_ramren", ramREN, 0);
        chk("rstmid_ramaddr", ramaddr, 0);
        chk("rstmid_dwait", dwait, 1);
        chk("rstmid_dload", dload, 0);
        @(posedge CLK); #1;
        chk("rstmid_edge_dwait", dwait, 1);
        chk("rstmid_edge_ramren", ramREN, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rstmid_idle_ramren", ramREN, 0);
        @(negedge CLK);
        chk("rstmid_regnt_dwait", dwait, 0);
        chk("rstmid_regnt_dload", dload, 32'h77);
        dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 RST  in  1  reset, asynchronous and active-high.
REQ-004 iREN  in  1  instruction-side read request.
REQ-005 iaddr  in  32  instruction address (word_t).
REQ-006 dREN  in  1  data-side read request.
REQ-007 dWEN  in  1  data-side write request.
REQ-008 daddr  in  32  data address.
REQ-009 dstore  in  32  data write value.
REQ-010 iwait  out  1  high while the instruction request is not yet completed.
REQ-011 dwait  out  1  high while the data request is not yet completed.
REQ-012 iload  out  32  instruction read data, valid when iREN is high and iwait is low.
REQ-013 dload  out  32  data read data, valid when dREN is high and dwait is low.
REQ-014 ramREN  out  1  RAM read strobe.
REQ-015 ramWEN  out  1  RAM write strobe.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramstate  in  2  RAM status (ramstate_t: FREE, BUSY, ACCESS, ERROR).

Function
REQ-020 The FSM SHALL have three states: IDLE, IGNT, DGNT; the state register is the only grant storage.
REQ-021 IDLE: a data request (dREN|dWEN) SHALL go to DGNT; otherwise iREN SHALL go to IGNT; otherwise the FSM SHALL stay in IDLE.
REQ-022 Starvation override: in IDLE, iREN high with starve count == STARVE_LIMIT SHALL go to IGNT even when a data request is present.
REQ-023 RAM strobes SHALL be driven only in IGNT/DGNT, from the granted requester; in IDLE ramREN=ramWEN=0 and ramaddr=ramstore=0.
REQ-024 DGNT with dWEN high SHALL drive a write (ramWEN=1, ramREN=0), even when dREN is also high.
REQ-025 In a granted state with ramstate==ACCESS, the granted wait SHALL be low for that cycle only, and the FSM SHALL return to IDLE on the next edge.
REQ-026 Completion SHALL be combinational on ramstate: load data passes ramload through in the same cycle.
REQ-027 ramstate==ERROR SHALL keep the wait high and return the FSM to IDLE, so the request re-arbitrates.
REQ-028 If the granted requester drops its request before ACCESS, the FSM SHALL return to IDLE next edge with no completion.
REQ-029 A non-granted requester's wait SHALL be high while its request is high, and low while its request is low.
REQ-030 Minimum latency SHALL be: request in IDLE at edge N -> grant at N+1 -> completion in the first ACCESS cycle; back-to-back transfers have one IDLE turnaround cycle.
REQ-031 Starve count SHALL increment (saturating at STARVE_LIMIT) on each IDLE->DGNT with iREN high.
REQ-032 Starve count SHALL clear on IDLE->IGNT, and on IDLE->DGNT with iREN low.

Reset
REQ-033 RST high SHALL asynchronously force state=IDLE and starve count=0.
REQ-034 During reset: ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0; iwait/dwait follow REQ-029.
REQ-035 Reset asserted mid-transfer SHALL abandon the transfer with no completion reported.

Configuration
REQ-036 Macro ARB_STARVE_GUARD_EN SHALL control the starvation guard.
REQ-037 With the macro defined, REQ-022/031/032 SHALL apply.
REQ-038 Without it, the counter logic SHALL be absent and data SHALL always win in IDLE (strict priority).

Structure
REQ-039 arb_state_t (IDLE, IGNT, DGNT) and the default ARB_STARVE_LIMIT SHALL live in cpu_types_pkg; ramstate_t and word_t SHALL be reused from there.
REQ-040 The starvation counter SHALL be a sub-module, arb_starve_counter (inc, clr, sat out), instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-041 Lone iREN=1, iaddr=0x40, ramstate ACCESS on 2nd grant cycle, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 one cycle after request; iwait low with iload=0xDEADBEEF that cycle; IDLE next.
REQ-042 Simultaneous iREN and dWEN (daddr=0x80, dstore=0x1234) from IDLE -> DGNT first with ramWEN=1, ramstore=0x1234; iwait stays high; IGNT after one IDLE turnaround.
REQ-043 Guard on, STARVE_LIMIT=4, iREN held, dREN re-asserted continuously -> exactly 4 data completions, then IGNT; count back to 0.
REQ-044 Guard off, same stimulus as REQ-043 -> IGNT never entered while dREN is high.
REQ-045 ramstate=ERROR during DGNT -> dwait stays high, IDLE next cycle, re-grant DGNT the cycle after.
REQ-046 RST pulsed mid-DGNT -> RAM strobes low immediately, state IDLE, count 0, no dwait low pulse.
